// File: rtl/memory_stage_if.sv
// memory_stage_if: variable-latency data-memory port (req/ready handshake, byte strobes).
interface memory_stage_if #(parameter int XLEN = 32);
  logic req;
  logic we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN/8-1:0] wstrb;
  logic ready;
  logic [XLEN-1:0] rdata;
  modport master(output req, we, addr, wdata, wstrb, input ready, rdata);
  modport slave(input req, we, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/memory_stage.sv
// memory_stage: RV32I MEM stage with variable-latency dmem port, load/store lane formatting and timeout.
// Optional MISALIGN_TRAP_EN adds misalignM and suppresses misaligned H/W accesses.
module memory_stage #(
  parameter int XLEN = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic regwriteM,
  input  logic memrwM,
  input  logic [1:0] wbselM,
  input  logic [2:0] funct3M,
  input  logic [4:0] rdM,
  input  logic [XLEN-1:0] ALUresM,
  input  logic [XLEN-1:0] data_writeM,
  input  logic [XLEN-1:0] pc4M,
  memory_stage_if.master dmem,
  output logic stallM,
  output logic buserrM,
  output logic regwriteW,
  output logic [1:0] wbselW,
  output logic [4:0] rdW,
  output logic [XLEN-1:0] ALUresW,
  output logic [XLEN-1:0] read_dataW,
  output logic [XLEN-1:0] pc4W
`ifdef MISALIGN_TRAP_EN
  ,
  output logic misalignM
`endif
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, stateNext;
  logic [7:0] waitCnt, waitCntNext;
  logic reqAccess, access, timeout, busy;
  logic [7:0] loadByte;
  logic [15:0] loadHalf;
  logic [XLEN-1:0] loadData;
  always_comb begin
    reqAccess = memrwM | (regwriteM & wbselM == 2'b00);
`ifdef MISALIGN_TRAP_EN
    misalignM = reqAccess & ((funct3M[1:0] == 2'b01 & ALUresM[0]) | (funct3M[1] & |ALUresM[1:0]));
    access = reqAccess & !misalignM;
`else
    access = reqAccess;
`endif
    timeout = state == WAIT & !dmem.ready & waitCnt == 8'(MAX_WAIT);
    busy = access & !(dmem.ready | timeout);
    stallM = !rst & busy;
    stateNext = busy ? WAIT : IDLE;
    waitCntNext = busy ? waitCnt + 8'd1 : 8'd0;
    // Request drops on the timeout cycle so the memory sees the access abandoned.
    dmem.req = !rst & access & !timeout;
    dmem.we = access & memrwM;
    dmem.addr = access ? {ALUresM[XLEN-1:2], 2'b00} : '0;
    dmem.wdata = !access ? '0 :
                 funct3M[1:0] == 2'b00 ? {4{data_writeM[7:0]}} :
                 funct3M[1:0] == 2'b01 ? {2{data_writeM[15:0]}} : data_writeM;
    dmem.wstrb = !(access & memrwM) ? 4'b0000 :
                 funct3M[1:0] == 2'b00 ? 4'b0001 << ALUresM[1:0] :
                 funct3M[1:0] == 2'b01 ? 4'b0011 << {ALUresM[1], 1'b0} : 4'b1111;
    loadByte = 8'(dmem.rdata >> {ALUresM[1:0], 3'b000});
    loadHalf = ALUresM[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    loadData = funct3M[1:0] == 2'b00 ? {{24{!funct3M[2] & loadByte[7]}}, loadByte} :
               funct3M[1:0] == 2'b01 ? {{16{!funct3M[2] & loadHalf[15]}}, loadHalf} : dmem.rdata;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= stateNext;
      waitCnt <= waitCntNext;
    end
  // MEM/WB register: a stall inserts a bubble by clearing only the write enable.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regwriteW <= 1'b0;
      wbselW <= '0;
      rdW <= '0;
      ALUresW <= '0;
      read_dataW <= '0;
      pc4W <= '0;
      buserrM <= 1'b0;
    end else begin
      buserrM <= timeout & access;
      if (stallM) regwriteW <= 1'b0;
      else begin
`ifdef MISALIGN_TRAP_EN
        regwriteW <= regwriteM & !misalignM;
`else
        regwriteW <= regwriteM;
`endif
        wbselW <= wbselM;
        rdW <= rdM;
        ALUresW <= ALUresM;
        read_dataW <= timeout ? '0 : loadData;
        pc4W <= pc4M;
      end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed plus randomized transactions checked against a behavioural load/store model.
module tb_memory_stage;
  localparam int MAX_WAIT = 15;
  logic clk = 0, rst = 1;
  logic regwriteM = 0, memrwM = 0;
  logic [1:0] wbselM = 2'b01;
  logic [2:0] funct3M = 0;
  logic [4:0] rdM = 0;
  logic [31:0] ALUresM = 0, data_writeM = 0, pc4M = 0;
  logic stallM, buserrM, regwriteW;
  logic [1:0] wbselW;
  logic [4:0] rdW;
  logic [31:0] ALUresW, read_dataW, pc4W;
`ifdef MISALIGN_TRAP_EN
  logic misalignM;
`endif
  int checks = 0, errors = 0;
  memory_stage_if dmem();
  memory_stage #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .regwriteM(regwriteM), .memrwM(memrwM), .wbselM(wbselM),
    .funct3M(funct3M), .rdM(rdM), .ALUresM(ALUresM), .data_writeM(data_writeM), .pc4M(pc4M),
    .dmem(dmem.master), .stallM(stallM), .buserrM(buserrM), .regwriteW(regwriteW),
    .wbselW(wbselW), .rdW(rdW), .ALUresW(ALUresW), .read_dataW(read_dataW), .pc4W(pc4W)
`ifdef MISALIGN_TRAP_EN
    , .misalignM(misalignM)
`endif
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int unsigned off = a % 4;
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return b >= 128 ? b - 256 : b;
      3'd1: return h >= 32768 ? h - 65536 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] refStrb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    case (f3)
      3'd0: return 4'(1 << off);
      3'd1: return 4'(3 << (2 * (off / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0: return (d & 32'hFF) * 32'h01010101;
      3'd1: return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic idleCycle();
    logic [31:0] alu = $urandom;
    @(negedge clk);
    regwriteM = 1; memrwM = 0; wbselM = 2'b01; ALUresM = alu; dmem.ready = 0;
    #1;
    check("idle_req", dmem.req, 0);
    check("idle_stall", stallM, 0);
    check("idle_addr", dmem.addr, 0);
    check("idle_wstrb", dmem.wstrb, 0);
    @(posedge clk); #1;
    check("buserr_clear", buserrM, 0);
    check("alu_regwrite", regwriteW, 1);
    check("alu_res", ALUresW, alu);
    check("alu_wbsel", wbselW, 2'b01);
  endtask

  // lat: cycles before ready; lat > MAX_WAIT means ready never comes in time.
  task automatic doTxn(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int lat);
    int expStalls = lat < MAX_WAIT ? lat : MAX_WAIT;
    bit tmo = lat > MAX_WAIT;
    logic [4:0] rdv = 5'($urandom_range(1, 31));
    logic [31:0] pc = $urandom;
    @(negedge clk);
    regwriteM = !st; memrwM = st; wbselM = 2'b00; funct3M = f3; rdM = rdv;
    ALUresM = a; data_writeM = d; pc4M = pc;
    for (int c = 0; c <= expStalls; c++) begin
      if (c > 0) @(negedge clk);
      dmem.ready = c == lat;
      dmem.rdata = c == lat ? rd : $urandom;
      #1;
      if (c == 0) begin
        check("addr", dmem.addr, a & ~32'h3);
        check("we", dmem.we, st);
        check("wstrb", dmem.wstrb, st ? refStrb(f3, a) : 4'h0);
        if (st) check("wdata", dmem.wdata, refWdata(f3, d));
      end
      check("stall", stallM, c < expStalls);
      check("req", dmem.req, !(tmo && c == MAX_WAIT));
      @(posedge clk); #1;
      if (c < expStalls) check("bubble", regwriteW, 0);
      else begin
        check("regwriteW", regwriteW, !st);
        check("rdW", rdW, rdv);
        check("ALUresW", ALUresW, a);
        check("pc4W", pc4W, pc);
        check("wbselW", wbselW, 2'b00);
        check("buserr", buserrM, tmo);
        if (!st) check("read_data", read_dataW, tmo ? 32'h0 : refLoad(f3, a, rd));
      end
    end
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    bit st;
    int lat;
    dmem.ready = 0;
    dmem.rdata = 0;
    #2;
    check("rst_req", dmem.req, 0);
    check("rst_stall", stallM, 0);
    check("rst_buserr", buserrM, 0);
    check("rst_regwriteW", regwriteW, 0);
    check("rst_read_dataW", read_dataW, 0);
    check("rst_pc4W", pc4W, 0);
    @(negedge clk);
    rst = 0;
    idleCycle();
    doTxn(1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0);
    check("sw_wstrb_const", refStrb(3'd2, 32'h100), 4'hF);
    idleCycle();
    doTxn(1, 3'd0, 32'h103, 32'h000000AB, 0, 2);
    idleCycle();
    doTxn(0, 3'd0, 32'h102, 0, 32'h00800000, 0);
    check("lb_const", read_dataW, 32'hFFFFFF80);
    doTxn(0, 3'd4, 32'h102, 0, 32'h00800000, 1);
    check("lbu_const", read_dataW, 32'h00000080);
    doTxn(0, 3'd1, 32'h102, 0, 32'h80010000, 0);
    check("lh_const", read_dataW, 32'hFFFF8001);
    idleCycle();
    doTxn(0, 3'd2, 32'h200, 0, 32'h12345678, 100);
    check("timeout_data", read_dataW, 0);
    idleCycle();
    doTxn(0, 3'd2, 32'h204, 0, 32'hCAFEF00D, MAX_WAIT);
    idleCycle();
    // Reset in the middle of an outstanding load.
    @(negedge clk);
    regwriteM = 1; memrwM = 0; wbselM = 2'b00; funct3M = 3'd2; ALUresM = 32'h300; rdM = 5'd7;
    dmem.ready = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("midrst_req", dmem.req, 0);
    check("midrst_stall", stallM, 0);
    check("midrst_regwriteW", regwriteW, 0);
    check("midrst_rdW", rdW, 0);
    check("midrst_ALUresW", ALUresW, 0);
    check("midrst_read_dataW", read_dataW, 0);
    @(negedge clk);
    rst = 0;
    regwriteM = 0;
    doTxn(0, 3'd2, 32'h304, 0, 32'h0BADF00D, 1);
    idleCycle();
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    regwriteM = 1; memrwM = 0; wbselM = 2'b00; funct3M = 3'd2; ALUresM = 32'h102; dmem.ready = 0;
    #1;
    check("mis_flag", misalignM, 1);
    check("mis_req", dmem.req, 0);
    check("mis_stall", stallM, 0);
    @(posedge clk); #1;
    check("mis_regwriteW", regwriteW, 0);
`else
    @(negedge clk);
    regwriteM = 1; memrwM = 0; wbselM = 2'b00; funct3M = 3'd2; ALUresM = 32'h102; dmem.ready = 1;
    #1;
    check("mis_addr", dmem.addr, 32'h100);
    check("mis_req", dmem.req, 1);
    @(posedge clk); #1;
`endif
    idleCycle();
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a = $urandom;
`ifdef MISALIGN_TRAP_EN
      a = f3[1:0] == 2'b01 ? a & ~32'h1 : f3[1] ? a & ~32'h3 : a;
`endif
      lat = $urandom_range(0, 9) == 0 ? 20 : $urandom_range(0, 3);
      doTxn(st, f3, a, $urandom, $urandom, lat);
      if (i % 4 == 3) idleCycle();
    end
    idleCycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
